// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmitter:
//                FSM state encoding, frame edge counts, common keyboard
//                command bytes and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_tx_state_t;

   // Device falling edge that clocks out the stop bit, and the one carrying ACK
   localparam logic [3:0] c_EDGE_STOP = 4'd10;
   localparam logic [3:0] c_EDGE_ACK  = 4'd11;

   // Common host-to-keyboard commands
   localparam logic [7:0] c_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] c_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] c_CMD_RESET    = 8'hFF;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd
   function automatic logic odd_parity(input logic [7:0] i_data);
      return ~^i_data;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Bundle of the host command handshake and the open-drain
//                PS/2 pin controls.
//                slave  : transmitter side (ps2_host_tx)
//                master : system side (command source + pad ring)
//  Signals     : tx_data[7:0], tx_start         command request
//                tx_busy, tx_done, tx_error     status / result pulses
//                ps2_clk_in, ps2_data_in        raw pin levels
//                ps2_clk_oe, ps2_data_oe        1 = pull pin low
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;

   modport slave (
      input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
      output tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
   );

   modport master (
      output tx_data, tx_start, ps2_clk_in, ps2_data_in,
      input  tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
   );
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : Brings one asynchronous PS/2 line into the clk domain with a
//                2-FF synchronizer, then only changes the filtered level once
//                four consecutive synchronized samples agree. Emits a
//                one-cycle pulse on each 1-to-0 transition of the filtered
//                level.
//  Ports       : clk, rst_n   clock / async active-low reset
//                i_pin        raw pin level
//                o_filt       filtered level (1 after reset)
//                o_fall       one-cycle falling-edge pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_filt,
   output logic o_fall
);

   logic       r_sync1;
   logic       r_sync2;
   logic [3:0] r_hist;
   logic       r_filt;
   logic       r_filt_d;

   // Idle PS/2 lines are pulled high, so everything resets to 1 to avoid a
   // spurious falling edge right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_hist   <= 4'hF;
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
      end else begin
         r_sync1  <= i_pin;
         r_sync2  <= r_sync1;
         r_hist   <= {r_hist[2:0], r_sync2};
         if (r_hist == 4'h0) begin
            r_filt <= 1'b0;
         end else if (r_hist == 4'hF) begin
            r_filt <= 1'b1;
         end
         r_filt_d <= r_filt;
      end
   end

   assign o_filt = r_filt;
   assign o_fall = r_filt_d & ~r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//                request-to-send, shifts out 8 data bits LSB first plus odd
//                parity and stop on device clock falling edges, checks the
//                device ACK and waits for the bus to return idle. A watchdog
//                aborts the frame if the device stops clocking.
//  Ports       : clk          system clock, rising edge
//                CPU_RESETN   async active-low reset
//                bus (slave)  tx_data/tx_start request, tx_busy/tx_done/
//                             tx_error status, ps2 pin levels and pull-downs
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ    = 82_000_000,
   parameter int unsigned INHIBIT_CYCLES = 8200,
   parameter int unsigned REQ_CYCLES     = 820,
   parameter int unsigned TIMEOUT_CYCLES = 1_230_000
)(
   input  logic         clk,
   input  logic         CPU_RESETN,
   ps2_host_tx_if.slave bus
);

   // One shared timer serves inhibit, request and watchdog phases. It is
   // sized to hold at least 20 ms at the system clock so the watchdog can be
   // retuned up to the protocol's longest device hold-off without widening.
   localparam int unsigned c_TMR_SPAN = max2(max2(INHIBIT_CYCLES, REQ_CYCLES),
                                             max2(TIMEOUT_CYCLES, CLK_FREQ_HZ / 50));
   localparam int          c_TMR_W    = $clog2(c_TMR_SPAN + 1);
   localparam logic [c_TMR_W-1:0] c_INH_LAST = c_TMR_W'(INHIBIT_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_REQ_LAST = c_TMR_W'(REQ_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t      r_state;
   logic [c_TMR_W-1:0] r_tmr;
   logic [3:0]         r_edge_cnt;
   logic [8:0]         r_shift;     // {parity, data}, LSB goes out first
   logic               r_clk_oe;
   logic               r_data_oe;
   logic               r_busy;
   logic               r_done;
   logic               r_error;

   logic               w_clk_filt;
   logic               w_clk_fall;
   logic               w_data_filt;
   logic               w_unused_data_fall;
   logic [3:0]         w_edge_next;
   logic               w_wd_state;
   logic               w_wd_expire;

   ps2_line_filter u_clk_filt (
      .clk    (clk),
      .rst_n  (CPU_RESETN),
      .i_pin  (bus.ps2_clk_in),
      .o_filt (w_clk_filt),
      .o_fall (w_clk_fall)
   );

   ps2_line_filter u_data_filt (
      .clk    (clk),
      .rst_n  (CPU_RESETN),
      .i_pin  (bus.ps2_data_in),
      .o_filt (w_data_filt),
      .o_fall (w_unused_data_fall)
   );

   assign w_edge_next = r_edge_cnt + 4'd1;
   assign w_wd_state  = (r_state == ST_SEND) || (r_state == ST_ACK) ||
                        (r_state == ST_WAIT_IDLE);
   // A falling edge in the same cycle reloads the watchdog rather than firing it
   assign w_wd_expire = w_wd_state && !w_clk_fall && (r_tmr == c_TO_LAST);

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state    <= ST_IDLE;
         r_tmr      <= '0;
         r_edge_cnt <= '0;
         r_shift    <= '0;
         r_clk_oe   <= 1'b0;
         r_data_oe  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;

         if (w_wd_expire) begin
            r_state   <= ST_IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_busy    <= 1'b0;
                  if (bus.tx_start) begin
                     r_shift    <= {odd_parity(bus.tx_data), bus.tx_data};
                     r_tmr      <= '0;
                     r_edge_cnt <= '0;
                     r_clk_oe   <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= ST_INHIBIT;
                  end
               end

               ST_INHIBIT: begin
                  if (r_tmr == c_INH_LAST) begin
                     r_tmr     <= '0;
                     r_data_oe <= 1'b1;       // start bit
                     r_state   <= ST_REQ;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end

               ST_REQ: begin
                  if (r_tmr == c_REQ_LAST) begin
                     r_tmr    <= '0;          // watchdog starts here
                     r_clk_oe <= 1'b0;        // hand the clock to the device
                     r_state  <= ST_SEND;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end

               ST_SEND: begin
                  if (w_clk_fall) begin
                     r_tmr      <= '0;
                     r_edge_cnt <= w_edge_next;
                     if (w_edge_next == c_EDGE_STOP) begin
                        r_data_oe <= 1'b0;    // stop bit = released line
                        r_state   <= ST_ACK;
                     end else begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[8:1]};
                     end
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end

               ST_ACK: begin
                  if (w_clk_fall) begin
                     r_tmr      <= '0;
                     r_edge_cnt <= c_EDGE_ACK;
                     if (!w_data_filt) begin
                        r_state <= ST_WAIT_IDLE;
                     end else begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
               end

               ST_WAIT_IDLE: begin
                  if (w_clk_fall) begin
                     r_tmr <= '0;
                  end else begin
                     r_tmr <= r_tmr + c_TMR_W'(1);
                  end
                  if (w_clk_filt && w_data_filt) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end

               default: begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ps2_clk_oe  = r_clk_oe;
   assign bus.ps2_data_oe = r_data_oe;
   assign bus.tx_busy     = r_busy;
   assign bus.tx_done     = r_done;
   assign bus.tx_error    = r_error;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with parameters and ports as listed in REQ-002 to REQ-015.
REQ-002 Parameter CLK_FREQ_HZ, default 82_000_000: system clock frequency.
REQ-003 Parameter INHIBIT_CYCLES, default 8200: clock-low inhibit time (100 us at 82 MHz).
REQ-004 Parameter REQ_CYCLES, default 820: data-low hold before clock release (10 us).
REQ-005 Parameter TIMEOUT_CYCLES, default 1_230_000: maximum gap between device clock edges (15 ms).
REQ-006 Port clk, input, 1 bit: system clock, 82 MHz domain, rising-edge.
REQ-007 Port CPU_RESETN, input, 1 bit: asynchronous active-low reset.
REQ-008 Port tx_data, input, 8 bits: command byte (e.g. 8'hED LED command).
REQ-009 Port tx_start, input, 1 bit: one-cycle request, sampled only in IDLE.
REQ-010 Port ps2_clk_in, input, 1 bit: raw PS2_CLK pin level, asynchronous.
REQ-011 Port ps2_data_in, input, 1 bit: raw PS2_DATA pin level, asynchronous.
REQ-012 Port ps2_clk_oe, output, 1 bit: 1 = drive PS2_CLK low, 0 = release (top level ties the pin to high-Z when released).
REQ-013 Port ps2_data_oe, output, 1 bit: 1 = drive PS2_DATA low.
REQ-014 Port tx_busy, output, 1 bit: high in every state except IDLE; the top level uses it to gate the kbd_ms receiver.
REQ-015 Ports tx_done and tx_error, outputs, 1 bit each: one-cycle pulses marking success and failure.

Function
REQ-016 The inputs ps2_clk_in and ps2_data_in SHALL pass a 2-FF synchronizer plus a 4-sample majority-stable filter; a falling edge is a 1-to-0 transition of the filtered clock.
REQ-017 The FSM SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-018 In IDLE with tx_start=1, the block SHALL latch tx_data, compute parity = ~^tx_data (odd), and enter INHIBIT; tx_busy rises the next cycle.
REQ-019 tx_start outside IDLE SHALL be ignored, with no queuing.
REQ-020 INHIBIT SHALL drive clk_oe=1 and data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-021 REQ SHALL drive clk_oe=1 and data_oe=1 (start bit) for REQ_CYCLES cycles, then go to SEND with clk_oe=0 and data_oe held at 1.
REQ-022 In SEND, the 4-bit edge counter SHALL advance on each filtered falling edge: edges 1-8 set data_oe = ~d[n-1] (LSB first), edge 9 sets data_oe = ~parity, and edge 10 sets data_oe=0 (stop) and moves to ACK.
REQ-023 In ACK, on the next falling edge, filtered data=0 SHALL move to WAIT_IDLE and data=1 SHALL pulse tx_error and return to IDLE.
REQ-024 WAIT_IDLE SHALL wait until filtered clk and data are both 1, then pulse tx_done for one cycle and return to IDLE.
REQ-025 In SEND, ACK and WAIT_IDLE, the watchdog SHALL reload on each falling edge; expiry after TIMEOUT_CYCLES SHALL release both lines, pulse tx_error and return to IDLE.
REQ-026 tx_done and tx_error SHALL never assert in the same cycle.
REQ-027 Both oe outputs SHALL be 0 in IDLE, and only data_oe may be 1 while clk_oe is 0.

Reset
REQ-028 CPU_RESETN=0 SHALL asynchronously force state IDLE, clk_oe=0, data_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters 0 and synchronizers 1.
REQ-029 Reset mid-frame SHALL release both lines in the same cycle and produce no done or error pulse.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state encoding, the edge-count constants (10 and 11), and the command constants 8'hED, 8'hF4 and 8'hFF.
REQ-031 The block SHALL contain one sub-module, ps2_line_filter (synchronizer, filter and falling-edge pulse), instantiated twice.

Verification
REQ-032 tx_data=8'hED, device model clocks at 12 kHz and ACKs: the bus shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_busy lasts the whole frame.
REQ-033 tx_data=8'h00: the parity bit is 1 (data_oe=0 at edge 9).
REQ-034 Device omits ACK (data=1 at edge 11): tx_error pulses once and tx_done stays 0.
REQ-035 Device stops clocking after edge 4: tx_error occurs TIMEOUT_CYCLES±1 cycles after edge 4 and both oe signals go to 0.
REQ-036 tx_start re-pulsed during INHIBIT: no restart, and the INHIBIT length stays exactly 8200 cycles.
REQ-037 CPU_RESETN pulsed low during SEND: oe signals go to 0 immediately, and no pulse occurs; a new tx_start after reset completes normally.
